// File: rtl/memcard_crc.sv
`default_nettype none
// ============================================================================
//  memcard_crc
//  Bit-serial CRC7 (CMD) and 4x CRC16 (DAT) tracker with a CSR read-back page.
//  Revision: 1.0
// ============================================================================
module memcard_crc #(
  parameter logic [3:0] csr_addr = 4'h1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        bit_ce,
  input  logic        cmd_active,
  input  logic        cmd_bit,
  input  logic        dat_active,
  input  logic [3:0]  dat_bits
);

  logic [6:0]        cmd_crc;
  logic [3:0][15:0]  dat_crc;
  logic [15:0]       cmd_count;
  logic [15:0]       dat_count;
  logic [31:0]       rd_data;

  logic sel;
  logic ctrl_wr;
  logic clr_cmd;
  logic clr_dat;
  logic cmd_step;
  logic dat_step;
  logic unused;

  assign sel      = (csr_a[13:10] == csr_addr);
  assign ctrl_wr  = sel && csr_we && (csr_a[2:0] == 3'd0);
  assign clr_cmd  = ctrl_wr && csr_di[0];
  assign clr_dat  = ctrl_wr && csr_di[1];
  assign cmd_step = bit_ce && cmd_active;
  assign dat_step = bit_ce && dat_active;
  assign unused   = ^{csr_a[9:3], csr_di[31:2]};

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    crc7_next = {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
    crc16_next = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // A clear on the same strobe wins: the coincident bit is dropped.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr_cmd) begin
      cmd_crc   <= 7'h00;
      cmd_count <= 16'h0000;
    end else if (cmd_step) begin
      cmd_crc <= crc7_next(cmd_crc, cmd_bit);
      if (cmd_count != 16'hFFFF) begin
        cmd_count <= cmd_count + 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr_dat) begin
      dat_crc   <= '0;
      dat_count <= 16'h0000;
    end else if (dat_step) begin
      for (int n = 0; n < 4; n++) begin
        dat_crc[n] <= crc16_next(dat_crc[n], dat_bits[n]);
      end
      if (dat_count != 16'hFFFF) begin
        dat_count <= dat_count + 16'd1;
      end
    end
  end

  always_comb begin
    rd_data = 32'h0000_0000;
    case (csr_a[2:0])
      3'd1:    rd_data = {25'd0, cmd_crc};
      3'd2:    rd_data = {16'd0, cmd_count};
      3'd3:    rd_data = {16'd0, dat_count};
      3'd4:    rd_data = {dat_crc[1], dat_crc[0]};
      3'd5:    rd_data = {dat_crc[3], dat_crc[2]};
      3'd6:    rd_data = {24'd0, cmd_crc, 1'b1};
      default: rd_data = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !sel) begin
      csr_do <= 32'h0000_0000;
    end else begin
      csr_do <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memcard_crc.sv
`default_nettype none
// ============================================================================
//  tb_memcard_crc
//  Directed stimulus with a queue scoreboard for memcard_crc CSR reads.
//  Revision: 1.0
// ============================================================================
module tb_memcard_crc;

  localparam logic [3:0] PAGE = 4'h1;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        bit_ce;
  logic        cmd_active;
  logic        cmd_bit;
  logic        dat_active;
  logic [3:0]  dat_bits;

  logic        rd_issue = 1'b0;
  logic        mon_flag = 1'b0;
  string       name_q[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  logic [39:0] cmd0;
  logic [39:0] cmd8;
  logic [71:0] msg;

  memcard_crc #(.csr_addr(PAGE)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .csr_a      (csr_a),
    .csr_we     (csr_we),
    .csr_di     (csr_di),
    .csr_do     (csr_do),
    .bit_ce     (bit_ce),
    .cmd_active (cmd_active),
    .cmd_bit    (cmd_bit),
    .dat_active (dat_active),
    .dat_bits   (dat_bits)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read data appears one cycle after the read is presented.
  always @(posedge sys_clk) mon_flag <= rd_issue;

  always @(negedge sys_clk) begin
    if (mon_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", csr_do);
      end else begin
        check(name_q.pop_front(), csr_do, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic ce, input logic ca, input logic cb, input logic da,
                       input logic [3:0] db, input logic we, input logic [2:0] idx,
                       input logic [31:0] di);
    bit_ce = ce; cmd_active = ca; cmd_bit = cb; dat_active = da; dat_bits = db;
    csr_we = we; csr_a = {PAGE, 7'd0, idx}; csr_di = di;
    @(negedge sys_clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] di);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, idx, di);
  endtask

  task automatic rd_page(input logic [3:0] page, input logic [2:0] idx,
                         input logic [31:0] exp, input string name);
    bit_ce = 1'b0; cmd_active = 1'b0; dat_active = 1'b0; csr_we = 1'b0;
    csr_a = {page, 7'd0, idx};
    name_q.push_back(name);
    exp_q.push_back(exp);
    rd_issue = 1'b1;
    @(negedge sys_clk);
    rd_issue = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string name);
    rd_page(PAGE, idx, exp, name);
  endtask

  task automatic cmd_frame(input logic [39:0] f);
    for (int i = 39; i >= 0; i--) drive(1'b1, 1'b1, f[i], 1'b0, 4'h0, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic dat_stream(input logic [71:0] m, input bit alt);
    for (int i = 71; i >= 0; i--)
      drive(1'b1, 1'b0, 1'b0, (!alt || ((71 - i) % 2 == 0)), {3'b000, m[i]}, 1'b0, 3'd0, 32'h0);
  endtask

  // Reference CRC16-CCITT (init 0) over the bits that were actually absorbed.
  function automatic logic [15:0] crc16_ref(input logic [71:0] m, input bit alt);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 71; i >= 0; i--) begin
      if (!alt || ((71 - i) % 2 == 0)) begin
        fb = c[15] ^ m[i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  initial begin
    cmd0 = 40'h40_0000_0000;
    cmd8 = 40'h48_0000_01AA;
    msg  = "123456789";
    sys_rst = 1'b1;
    bit_ce = 1'b0; cmd_active = 1'b0; cmd_bit = 1'b0; dat_active = 1'b0; dat_bits = 4'h0;
    csr_we = 1'b0; csr_a = 14'h0; csr_di = 32'h0;
    @(negedge sys_clk);
    repeat (3) idle();
    check("rst_csr_do", csr_do, 32'h0);
    sys_rst = 1'b0;
    idle();
    rd(3'd1, 32'h0, "rst_cmd_crc");
    rd(3'd2, 32'h0, "rst_cmd_count");
    rd(3'd3, 32'h0, "rst_dat_count");
    rd(3'd4, 32'h0, "rst_dat_crc01");
    rd(3'd5, 32'h0, "rst_dat_crc23");
    rd(3'd6, 32'h1, "rst_trailer");

    cmd_frame(cmd0);
    rd(3'd1, 32'h4A, "cmd0_crc");
    rd(3'd6, 32'h95, "cmd0_trailer");
    rd(3'd2, 32'd40, "cmd0_count");
    rd(3'd0, 32'h0, "ctrl_read");
    rd(3'd7, 32'h0, "idx7_read");

    wr(3'd0, 32'h1);
    cmd_frame(cmd8);
    rd(3'd1, 32'h43, "cmd8_crc");
    rd(3'd6, 32'h87, "cmd8_trailer");
    rd(3'd2, 32'd40, "cmd8_count");
    rd(3'd3, 32'h0, "cmd8_dat_count");
    rd(3'd4, 32'h0, "cmd8_dat_crc01");

    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'h43, "ignored_write_crc");
    csr_we = 1'b1; csr_a = {4'h2, 7'd0, 3'd0}; csr_di = 32'h3;
    @(negedge sys_clk);
    rd(3'd2, 32'd40, "offpage_clear_ignored");

    dat_stream(msg, 1'b0);
    rd(3'd4, 32'h0000_31C3, "dat_crc01");
    rd(3'd5, 32'h0, "dat_crc23");
    rd(3'd3, 32'd72, "dat_count");
    rd(3'd1, 32'h43, "dat_cmd_untouched");

    wr(3'd0, 32'h2);
    dat_stream(msg, 1'b1);
    rd(3'd4, {16'h0, crc16_ref(msg, 1'b1)}, "alt_dat_crc01");
    rd(3'd3, 32'd36, "alt_dat_count");

    // DAT clear lands mid-stream while CMD keeps shifting CMD0.
    wr(3'd0, 32'h3);
    for (int i = 39; i >= 21; i--) drive(1'b1, 1'b1, cmd0[i], 1'b1, 4'hF, 1'b0, 3'd0, 32'h0);
    drive(1'b1, 1'b1, cmd0[20], 1'b1, 4'hF, 1'b1, 3'd0, 32'h2);
    for (int i = 19; i >= 0; i--) drive(1'b1, 1'b1, cmd0[i], 1'b0, 4'h0, 1'b0, 3'd0, 32'h0);
    rd(3'd1, 32'h4A, "coinc_cmd_crc");
    rd(3'd2, 32'd40, "coinc_cmd_count");
    rd(3'd3, 32'h0, "coinc_dat_count");
    rd(3'd4, 32'h0, "coinc_dat_crc01");
    rd(3'd5, 32'h0, "coinc_dat_crc23");

    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1, 3'd0, 32'h1);
    rd(3'd2, 32'h0, "cmdclr_count");
    rd(3'd1, 32'h0, "cmdclr_crc");
    rd(3'd3, 32'd1, "cmdclr_dat_count");
    rd(3'd4, 32'h0000_1021, "cmdclr_dat_crc01");

    rd_page(4'h2, 3'd3, 32'h0, "offpage_read");

    wr(3'd0, 32'h1);
    for (int i = 0; i < 65537; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 32'h0);
    rd(3'd2, 32'h0000_FFFF, "sat_cmd_count");
    rd(3'd1, 32'h0, "sat_cmd_crc");

    for (int i = 39; i >= 20; i--) drive(1'b1, 1'b1, cmd8[i], 1'b1, 4'hA, 1'b0, 3'd0, 32'h0);
    sys_rst = 1'b1;
    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 3'd0, 32'h0);
    sys_rst = 1'b0;
    rd(3'd1, 32'h0, "mrst_cmd_crc");
    rd(3'd2, 32'h0, "mrst_cmd_count");
    rd(3'd3, 32'h0, "mrst_dat_count");
    rd(3'd4, 32'h0, "mrst_dat_crc01");
    rd(3'd5, 32'h0, "mrst_dat_crc23");
    rd(3'd6, 32'h1, "mrst_trailer");

    repeat (4) idle();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
